// File: rtl/tt_seq_pkg.sv
// Shared constants and state encoding for the tt_seq_ctrl command sequencer.
package tt_seq_pkg;

    localparam int unsigned IDX_W       = 4;
    localparam int unsigned DEF_N_IN    = 4;
    localparam int unsigned DEF_N_OUT   = 2;
    localparam int unsigned DEF_TIMEOUT = 255;

    typedef logic [2:0] state_t;

    localparam state_t StLoad  = 3'd0;
    localparam state_t StStart = 3'd1;
    localparam state_t StWait  = 3'd2;
    localparam state_t StFetch = 3'd3;
    localparam state_t StSend  = 3'd4;

endpackage

// File: rtl/tt_seq_ctrl_if.sv
// Pin-side streams and engine port of tt_seq_ctrl; slave is the sequencer's view.
interface tt_seq_ctrl_if;
    import tt_seq_pkg::*;

    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             eng_wr_en;
    logic [IDX_W-1:0] eng_addr;
    logic [7:0]       eng_wdata;
    logic             eng_start;
    logic             eng_done;
    logic             eng_rd_en;
    logic [7:0]       eng_rdata;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             error;

    modport slave (
        input  in_data, in_valid, eng_done, eng_rdata, out_ready,
        output in_ready, eng_wr_en, eng_addr, eng_wdata, eng_start, eng_rd_en,
        output out_data, out_valid, busy, error
    );

    modport master (
        output in_data, in_valid, eng_done, eng_rdata, out_ready,
        input  in_ready, eng_wr_en, eng_addr, eng_wdata, eng_start, eng_rd_en,
        input  out_data, out_valid, busy, error
    );

endinterface

// File: rtl/tt_seq_wdog.sv
// WAIT-state watchdog: tc flags the enabled cycle in which the count reaches TIMEOUT.
module tt_seq_wdog import tt_seq_pkg::*; #(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if (clr) begin
            cnt_q <= 8'd0;
        end else if (en) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign tc = en && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/tt_seq_ctrl.sv
// Byte-serial command sequencer: load operands, start engine, fetch and stream results.
// Optional WAIT watchdog enabled by defining TT_SEQ_TIMEOUT_EN.
module tt_seq_ctrl import tt_seq_pkg::*; #(
    parameter int unsigned N_IN    = DEF_N_IN,
    parameter int unsigned N_OUT   = DEF_N_OUT,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    tt_seq_ctrl_if.slave bus
);

    localparam logic [IDX_W-1:0] KLast = IDX_W'(N_IN - 1);
    localparam logic [IDX_W-1:0] JLast = IDX_W'(N_OUT - 1);

    if (N_IN < 1 || N_IN > 16 || N_OUT < 1 || N_OUT > 16 || TIMEOUT < 1 || TIMEOUT > 255)
    begin : g_param_err
        $error("tt_seq_ctrl: parameter out of range");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d, j_q, j_d;
    logic             wr_en_q, start_q, fresh_q;
    logic [IDX_W-1:0] waddr_q;
    logic [7:0]       wdata_q, data_q;
    logic             accept, wd_tc;

    assign accept = bus.in_valid && (state_q == StLoad);

`ifdef TT_SEQ_TIMEOUT_EN
    logic error_q;

    tt_seq_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk(clk),
        .rst(rst),
        .clr(state_q == StStart),
        .en (state_q == StWait),
        .tc (wd_tc)
    );

    // A done on the terminal-count cycle takes priority over the abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
        end else if (state_q == StWait && wd_tc && !bus.eng_done) begin
            error_q <= 1'b1;
        end else if (accept) begin
            error_q <= 1'b0;
        end
    end

    assign bus.error = error_q;
`else
    assign wd_tc     = 1'b0;
    assign bus.error = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        case (state_q)
            StLoad: begin
                if (accept) begin
                    if (k_q == KLast) begin
                        k_d     = '0;
                        state_d = StStart;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            StStart: state_d = StWait;
            StWait: begin
                if (bus.eng_done) begin
                    j_d     = '0;
                    state_d = StFetch;
                end else if (wd_tc) begin
                    k_d     = '0;
                    state_d = StLoad;
                end
            end
            StFetch: state_d = StSend;
            StSend: begin
                if (bus.out_ready) begin
                    if (j_q == JLast) begin
                        k_d     = '0;
                        state_d = StLoad;
                    end else begin
                        j_d     = j_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLoad;
            k_q     <= '0;
            j_q     <= '0;
            wr_en_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'd0;
            start_q <= 1'b0;
            fresh_q <= 1'b0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            wr_en_q <= accept;
            if (accept) begin
                waddr_q <= k_q;
                wdata_q <= bus.in_data;
            end
            // Registered start lands one cycle after the final operand write.
            start_q <= (state_q == StStart);
            fresh_q <= (state_q == StFetch);
            if (fresh_q) begin
                data_q <= bus.eng_rdata;
            end
        end
    end

    // eng_rdata is only valid in the first SEND cycle; pass it through then, hold it after.
    assign bus.out_data  = fresh_q ? bus.eng_rdata : data_q;
    assign bus.out_valid = (state_q == StSend);
    assign bus.in_ready  = (state_q == StLoad);
    assign bus.busy      = (state_q != StLoad);
    assign bus.eng_wr_en = wr_en_q;
    assign bus.eng_wdata = wdata_q;
    assign bus.eng_start = start_q;
    assign bus.eng_rd_en = (state_q == StFetch);
    assign bus.eng_addr  = (state_q == StFetch) ? j_q : waddr_q;

endmodule

// File: tb/tb_tt_seq_ctrl.sv
// Scoreboard bench for tt_seq_ctrl; watchdog tests run when TT_SEQ_TIMEOUT_EN is defined.
module tb_tt_seq_ctrl;
    import tt_seq_pkg::*;

    localparam int unsigned N_IN  = 4;
    localparam int unsigned N_OUT = 2;
    localparam int unsigned TMO   = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tt_seq_ctrl_if bus();

    tt_seq_ctrl #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc = 0, trig_cyc = 0, start_cyc = 0;
    int n_start = 0, n_rd = 0;
    bit ov_prev = 0, fire_prev = 0, rdy_pending = 0, acc_last = 0;
    logic [7:0]  data_prev;
    logic [11:0] exp_wr_q[$];
    logic [7:0]  exp_out_q[$];
    logic [7:0]  res[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Engine: registered result read, garbage whenever not being read.
    always @(posedge clk) begin
        if (bus.eng_rd_en) bus.eng_rdata <= res[bus.eng_addr];
        else               bus.eng_rdata <= 8'hEE;
    end

    always @(negedge clk) begin
        if (rst) begin
            ov_prev     = 0;
            fire_prev   = 0;
            rdy_pending = 0;
            acc_last    = 0;
        end else begin
            int  s;
            bit  fire;
            s = int'(bus.eng_wr_en) + int'(bus.eng_start) + int'(bus.eng_rd_en);
            if (s != 0) check_eq("strobe_excl", s, 1);
            if (acc_last) check_eq("err_clr", bus.error, 0);
            if (bus.eng_wr_en) begin
                check_eq("wr_lat", cyc - acc_cyc, 1);
                if (exp_wr_q.size() == 0) check_eq("wr_unexp_q", exp_wr_q.size(), 1);
                else check_eq("wr", {bus.eng_addr, bus.eng_wdata}, exp_wr_q.pop_front());
            end
            acc_last = bus.in_valid && bus.in_ready;
            if (acc_last) acc_cyc = cyc;
            if (bus.eng_start) begin
                check_eq("start_lat", cyc - acc_cyc, 2);
                n_start++;
                start_cyc = cyc;
            end
            if (bus.eng_rd_en) begin
                check_eq("rd_lat", cyc - trig_cyc, 1);
                n_rd++;
            end
            if (bus.out_valid) begin
                if (!ov_prev) check_eq("ov_lat", cyc - trig_cyc, 2);
                else if (!fire_prev) check_eq("out_hold", bus.out_data, data_prev);
                data_prev = bus.out_data;
            end
            if (rdy_pending) check_eq("rdy_back", bus.in_ready, 1);
            rdy_pending = 0;
            fire = bus.out_valid && bus.out_ready;
            if (fire) begin
                if (exp_out_q.size() == 0) check_eq("out_unexp_q", exp_out_q.size(), 1);
                else check_eq("out", bus.out_data, exp_out_q.pop_front());
                trig_cyc    = cyc;
                rdy_pending = (exp_out_q.size() == 0);
            end
            ov_prev   = bus.out_valid;
            fire_prev = fire;
        end
    end

    task automatic check_reset_state(input string tag);
        check_eq(tag, {bus.in_ready, bus.eng_wr_en, bus.eng_addr, bus.eng_wdata, bus.eng_start,
                       bus.eng_rd_en, bus.out_data, bus.out_valid, bus.busy, bus.error},
                 {1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [3:0] k);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        check_eq("in_ready_wait", bus.in_ready, 1);
        exp_wr_q.push_back({k, b});
        @(posedge clk);
        #1;
    endtask

    // dly: cycles from start to done (-1: never); stall: hold out_ready low 5 cycles;
    // noise: stray done in LOAD/SEND and a 0xFF byte offered while busy.
    task automatic run_cmd(input logic [N_IN*8-1:0] ops, input logic [N_OUT*8-1:0] rs,
                           input int dly, input bit stall, input bit noise);
        int base_start = n_start;
        int base_rd    = n_rd;
        if (noise) begin
            bus.eng_done = 1'b1;
            repeat (2) @(posedge clk);
            #1 bus.eng_done = 1'b0;
        end
        for (int k = 0; k < int'(N_IN); k++) send_byte(ops[k*8 +: 8], 4'(k));
        bus.in_valid = noise;
        bus.in_data  = 8'hFF;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (bus.eng_start) break;
        end
        check_eq("start_seen", bus.eng_start, 1);
        check_eq("start_busy", bus.busy, 1);
        for (int j = 0; j < int'(N_OUT); j++) res[j] = rs[j*8 +: 8];
        bus.out_ready = !stall;
        if (dly < 0) begin
            for (int w = 0; w < 40; w++) begin
                @(negedge clk);
                if (bus.in_ready) break;
            end
            check_eq("wd_lat", cyc - start_cyc, TMO);
            check_eq("wd_error", bus.error, 1);
            check_eq("wd_idle", bus.busy, 0);
            repeat (3) @(negedge clk);
            check_eq("wd_sticky", bus.error, 1);
            @(posedge clk);
            #1;
        end else begin
            repeat (dly) @(posedge clk);
            #1;
            bus.eng_done = 1'b1;
            trig_cyc     = cyc;
            for (int j = 0; j < int'(N_OUT); j++) exp_out_q.push_back(rs[j*8 +: 8]);
            @(posedge clk);
            #1 bus.eng_done = 1'b0;
            if (stall) begin
                for (int w = 0; w < 20; w++) begin
                    @(negedge clk);
                    if (bus.out_valid) break;
                end
                check_eq("stall_valid", bus.out_valid, 1);
                if (noise) bus.eng_done = 1'b1;
                repeat (5) @(negedge clk);
                check_eq("stall_data", bus.out_data, rs[7:0]);
                @(posedge clk);
                #1;
                bus.eng_done  = 1'b0;
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
            end
            for (int w = 0; w < 40 && exp_out_q.size() > 0; w++) @(negedge clk);
            check_eq("out_drain", exp_out_q.size(), 0);
            @(negedge clk);
            check_eq("n_rd", n_rd - base_rd, N_OUT);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check_eq("n_start", n_start - base_start, 1);
        check_eq("wr_drain", exp_wr_q.size(), 0);
    endtask

    initial begin
        int base;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.eng_done  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_reset_state("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_cmd(32'h44332211, 16'hCDAB, 3, 1'b0, 1'b0);
        run_cmd(32'h04030201, 16'h3412, 3, 1'b1, 1'b0);
        run_cmd(32'h8899AABB, 16'h5A77, 4, 1'b1, 1'b1);

        // Abort a command half-way through the operands.
        base = n_start;
        send_byte(8'hA1, 4'd0);
        send_byte(8'hA2, 4'd1);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_state("mid_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("no_start", n_start, base);
        @(posedge clk);
        #1;
        run_cmd(32'hDEADBEEF, 16'h0F1E, 3, 1'b0, 1'b0);

`ifdef TT_SEQ_TIMEOUT_EN
        run_cmd(32'h01020304, 16'h0000, -1, 1'b0, 1'b0);
        run_cmd(32'h55667788, 16'hC3B2, 9, 1'b0, 1'b0);
`else
        run_cmd(32'h55667788, 16'hC3B2, 30, 1'b0, 1'b0);
`endif
        check_eq("final_error", bus.error, 0);
        check_eq("final_idle", bus.in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
